// File: rtl/mux_scan_reg_pkg.sv
// Shared definitions for the registered N-way selector with auto-scan:
// mode encoding and counter sizing helper.
package mux_scan_reg_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } scan_mode_e;

   // Bits needed to count 0..value-1, never less than one so a DWELL of 1 still has a counter.
   function automatic int clog2_min1(input int value);
      int result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/mux_scan_reg_if.sv
// Bus between the selector and whoever drives it: controls and channel data in,
// registered selection and status out.
interface mux_scan_reg_if
   import mux_scan_reg_pkg::*;
#(
   parameter int W     = 4,
   parameter int N     = 4,
   parameter int SEL_W = 2
);

   logic             enable;
   scan_mode_e       mode;
   logic             hold;
   logic [SEL_W-1:0] select;
   logic [N*W-1:0]   d;
   logic [W-1:0]     z;
   logic [SEL_W-1:0] chan;
   logic             wrap;
   logic             err;

   modport master (
      output enable, mode, hold, select, d,
      input  z, chan, wrap, err
   );

   modport slave (
      input  enable, mode, hold, select, d,
      output z, chan, wrap, err
   );

endinterface

// File: rtl/mux_scan_reg_scan_counter.sv
// Round-robin channel counter with a per-channel dwell counter; produces the scan
// channel and a strobe that is set on the step from the last channel back to 0.
module mux_scan_reg_scan_counter
   import mux_scan_reg_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = 2,
   parameter int DWELL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   input  logic             load,
   input  logic [SEL_W-1:0] load_value,
   output logic [SEL_W-1:0] sc,
   output logic             wrap_strobe
);

   localparam int DC_W = clog2_min1(DWELL);

   logic [DC_W-1:0] dc;
   logic            dwell_done;
   logic            last_chan;
   logic            load_in_range;

   assign dwell_done    = (dc == DC_W'(DWELL - 1));
   assign last_chan     = (sc == SEL_W'(N - 1));
   assign load_in_range = (32'(load_value) < N);

   // The strobe keeps its value while neither loading nor advancing, so a wrap
   // followed by a hold or disable is still reported once scanning resumes.
   always_ff @(posedge clk) begin
      if (reset) begin
         sc          <= '0;
         dc          <= '0;
         wrap_strobe <= 1'b0;
      end else if (load) begin
         sc          <= load_in_range ? load_value : '0;
         dc          <= '0;
         wrap_strobe <= 1'b0;
      end else if (advance) begin
         if (dwell_done) begin
            dc          <= '0;
            sc          <= last_chan ? '0 : sc + SEL_W'(1);
            wrap_strobe <= last_chan;
         end else begin
            dc          <= dc + DC_W'(1);
            wrap_strobe <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_scan_reg.sv
// N-input, W-bit selector with registered output, active-low enable, hold and
// round-robin auto-scan; D is only ever sampled on the clock edge.
module mux_scan_reg
   import mux_scan_reg_pkg::*;
#(
   parameter int W     = 4,
   parameter int N     = 4,
   parameter int SEL_W = 2,
   parameter int DWELL = 1
) (
   input logic            clk,
   input logic            reset,
   mux_scan_reg_if.slave  bus
);

   logic             run;
   logic             manual_run;
   logic             scan_run;
   logic [SEL_W-1:0] sc;
   logic             wrap_strobe;
   logic [SEL_W-1:0] sel_idx;
   logic             sel_in_range;
   logic [W-1:0]     sel_data;
   logic [W-1:0]     z_q;
   logic [SEL_W-1:0] chan_q;
   logic             wrap_q;
   logic             err_q;

   assign run        = !bus.enable && !bus.hold;
   assign manual_run = run && (bus.mode == MODE_MANUAL);
   assign scan_run   = run && (bus.mode == MODE_SCAN);

   mux_scan_reg_scan_counter #(
      .N     (N),
      .SEL_W (SEL_W),
      .DWELL (DWELL)
   ) u_scan_counter (
      .clk         (clk),
      .reset       (reset),
      .advance     (scan_run),
      .load        (manual_run),
      .load_value  (bus.select),
      .sc          (sc),
      .wrap_strobe (wrap_strobe)
   );

   // Unused select codes fall through the loop and leave the data at zero.
   always_comb begin
      sel_idx      = manual_run ? bus.select : sc;
      sel_in_range = (32'(sel_idx) < N);
      sel_data     = '0;
      for (int k = 0; k < N; k++) begin
         if (sel_idx == SEL_W'(k)) begin
            sel_data = bus.d[k*W +: W];
         end
      end
   end

   // Disable forces the data outputs low like the TTL part but keeps Chan.
   always_ff @(posedge clk) begin
      if (reset) begin
         z_q    <= '0;
         chan_q <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (bus.enable) begin
         z_q    <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (bus.hold) begin
         wrap_q <= 1'b0;
      end else begin
         z_q    <= sel_data;
         chan_q <= sel_idx;
         err_q  <= manual_run && !sel_in_range;
         wrap_q <= scan_run && wrap_strobe;
      end
   end

   assign bus.z    = z_q;
   assign bus.chan = chan_q;
   assign bus.wrap = wrap_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Scoreboard bench for mux_scan_reg: three configurations (N=4/DWELL=2,
// N=3/DWELL=1, N=4/DWELL=3) driven from per-scenario step tables.
module tb_mux_scan_reg;
   import mux_scan_reg_pkg::*;

   typedef struct {
      logic       rst;
      logic       en;
      logic       hold;
      scan_mode_e mode;
      logic [1:0] sel;
      logic [7:0] exp;
   } step_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q[$];

   mux_scan_reg_if #(.W(4), .N(4), .SEL_W(2)) a_if ();
   mux_scan_reg_if #(.W(4), .N(3), .SEL_W(2)) b_if ();
   mux_scan_reg_if #(.W(4), .N(4), .SEL_W(2)) c_if ();

   mux_scan_reg #(.W(4), .N(4), .SEL_W(2), .DWELL(2)) dut_a (
      .clk (clk), .reset (reset), .bus (a_if)
   );
   mux_scan_reg #(.W(4), .N(3), .SEL_W(2), .DWELL(1)) dut_b (
      .clk (clk), .reset (reset), .bus (b_if)
   );
   mux_scan_reg #(.W(4), .N(4), .SEL_W(2), .DWELL(3)) dut_c (
      .clk (clk), .reset (reset), .bus (c_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      logic [7:0] exp;
      logic [7:0] obs;
      reset     = 1'b1;
      a_if.d    = 16'h3A15;
      a_if.mode = MODE_MANUAL;
      a_if.select = 2'd2;
      b_if.d    = 12'hFFF;
      c_if.d    = 16'hFFFF;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h00);
         exp_q.push_back(8'h00);
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {a_if.z, a_if.chan, a_if.wrap, a_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_a cycle %0d: got %h, expected %h", i, obs, exp);
         end
         exp = exp_q.pop_front();
         obs = {b_if.z, b_if.chan, b_if.wrap, b_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_b cycle %0d: got %h, expected %h", i, obs, exp);
         end
         exp = exp_q.pop_front();
         obs = {c_if.z, c_if.chan, c_if.wrap, c_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_c cycle %0d: got %h, expected %h", i, obs, exp);
         end
      end
      reset = 1'b0;
      exp_q.push_back({4'hA, 2'd2, 1'b0, 1'b0});
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      obs = {a_if.z, a_if.chan, a_if.wrap, a_if.err};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL reset_release: got %h, expected %h", obs, exp);
      end
   endtask

   task automatic test_manual();
      logic [7:0] exp;
      logic [7:0] obs;
      reset  = 1'b0;
      a_if.d = 16'h3210;
      a_if.mode = MODE_MANUAL;
      for (int s = 0; s < 4; s++) begin
         a_if.select = 2'(s);
         exp_q.push_back({4'(s), 2'(s), 1'b0, 1'b0});
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {a_if.z, a_if.chan, a_if.wrap, a_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL manual sel=%0d: got %h, expected %h", s, obs, exp);
         end
      end
   endtask

   task automatic test_scan();
      logic [7:0] exp;
      logic [7:0] obs;
      int chan_seq[9] = '{1, 1, 2, 2, 3, 3, 0, 0, 1};
      reset = 1'b0;
      a_if.d = 16'h3210;
      a_if.mode = MODE_MANUAL;
      a_if.select = 2'd1;
      exp_q.push_back({4'h1, 2'd1, 1'b0, 1'b0});
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      obs = {a_if.z, a_if.chan, a_if.wrap, a_if.err};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL scan_preload: got %h, expected %h", obs, exp);
      end
      a_if.mode = MODE_SCAN;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back({4'(chan_seq[i]), 2'(chan_seq[i]), (i == 6), 1'b0});
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {a_if.z, a_if.chan, a_if.wrap, a_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL scan step %0d: got %h, expected %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_enable_hold();
      logic [7:0] exp;
      logic [7:0] obs;
      step_t steps[9] = '{
         '{1'b0, 1'b0, 1'b0, MODE_MANUAL, 2'd2, {4'h2, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd0, {4'h2, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b1, MODE_SCAN,   2'd0, {4'h2, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b1, MODE_SCAN,   2'd0, {4'h2, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b1, MODE_SCAN,   2'd0, {4'h2, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b1, 1'b0, MODE_SCAN,   2'd0, {4'h0, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b1, 1'b0, MODE_SCAN,   2'd0, {4'h0, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd0, {4'h2, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd0, {4'h3, 2'd3, 1'b0, 1'b0}}
      };
      a_if.d = 16'h3210;
      foreach (steps[i]) begin
         reset       = steps[i].rst;
         a_if.enable = steps[i].en;
         a_if.hold   = steps[i].hold;
         a_if.mode   = steps[i].mode;
         a_if.select = steps[i].sel;
         exp_q.push_back(steps[i].exp);
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {a_if.z, a_if.chan, a_if.wrap, a_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL enable_hold step %0d: got %h, expected %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [7:0] exp;
      logic [7:0] obs;
      step_t steps[8] = '{
         '{1'b0, 1'b0, 1'b0, MODE_MANUAL, 2'd3, {4'h0, 2'd3, 1'b0, 1'b1}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'h7, 2'd0, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'h8, 2'd1, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'h9, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'h7, 2'd0, 1'b1, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'h8, 2'd1, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_MANUAL, 2'd2, {4'h9, 2'd2, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_MANUAL, 2'd0, {4'h7, 2'd0, 1'b0, 1'b0}}
      };
      b_if.d = 12'h987;
      foreach (steps[i]) begin
         reset       = steps[i].rst;
         b_if.enable = steps[i].en;
         b_if.hold   = steps[i].hold;
         b_if.mode   = steps[i].mode;
         b_if.select = steps[i].sel;
         exp_q.push_back(steps[i].exp);
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {b_if.z, b_if.chan, b_if.wrap, b_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL out_of_range step %0d: got %h, expected %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [7:0] exp;
      logic [7:0] obs;
      step_t steps[7] = '{
         '{1'b0, 1'b0, 1'b0, MODE_MANUAL, 2'd3, {4'hD, 2'd3, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'hD, 2'd3, 1'b0, 1'b0}},
         '{1'b1, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'h0, 2'd0, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'hA, 2'd0, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'hA, 2'd0, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'hA, 2'd0, 1'b0, 1'b0}},
         '{1'b0, 1'b0, 1'b0, MODE_SCAN,   2'd3, {4'hB, 2'd1, 1'b0, 1'b0}}
      };
      c_if.d = 16'hDCBA;
      foreach (steps[i]) begin
         reset       = steps[i].rst;
         c_if.enable = steps[i].en;
         c_if.hold   = steps[i].hold;
         c_if.mode   = steps[i].mode;
         c_if.select = steps[i].sel;
         exp_q.push_back(steps[i].exp);
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {c_if.z, c_if.chan, c_if.wrap, c_if.err};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL reset_mid_scan step %0d: got %h, expected %h", i, obs, exp);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      a_if.enable = 1'b0; a_if.hold = 1'b0; a_if.mode = MODE_MANUAL; a_if.select = '0; a_if.d = '0;
      b_if.enable = 1'b0; b_if.hold = 1'b0; b_if.mode = MODE_MANUAL; b_if.select = '0; b_if.d = '0;
      c_if.enable = 1'b0; c_if.hold = 1'b0; c_if.mode = MODE_MANUAL; c_if.select = '0; c_if.d = '0;
      $display("[TB] starting mux_scan_reg bench");
      test_reset();
      test_manual();
      test_scan();
      test_enable_hold();
      test_out_of_range();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
